// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Request/response bundle for the bit-serial subtractor.
//                The master issues start with the operands; the slave
//                reports busy/done and the registered result.
//                borrow_in exists only when SUB_BORROW_IN_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SUB_BORROW_IN_EN
    logic             borrow_in;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
`ifdef SUB_BORROW_IN_EN
        output borrow_in,
`endif
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
`ifdef SUB_BORROW_IN_EN
        input  borrow_in,
`endif
        output busy, done, diff, borrow_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor, diff = a - b - bin,
//                processed LSB first through one full-subtractor cell with
//                a registered borrow. Handshake: start / busy / done.
//                Optional feature macro: SUB_BORROW_IN_EN (adds borrow_in,
//                loaded into the borrow register on the accepting edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire                  clk,
    input  wire                  rst,
    serial_subtractor_if.slave   bus
);
    localparam int               c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sd;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;

    logic               w_bin;
    logic               w_d;
    logic               w_bnext;
    logic [WIDTH-1:0]   w_sd_next;

`ifdef SUB_BORROW_IN_EN
    assign w_bin = bus.borrow_in;
`else
    assign w_bin = 1'b0;
`endif

    // Full-subtractor cell on the current LSBs, plus the difference register
    // with the new bit shifted in at the MSB (after WIDTH steps bit 0 lands
    // at position 0).
    always_comb begin
        w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
        w_bnext   = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
        w_sd_next = (r_sd >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    end

    // Sequencer: accept operands, step one bit per edge, publish the result
    // only on the final step so partial values are never visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_sa         <= '0;
            r_sb         <= '0;
            r_sd         <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_br    <= w_bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    r_sa <= r_sa >> 1;
                    r_sb <= r_sb >> 1;
                    r_sd <= w_sd_next;
                    r_br <= w_bnext;
                    if (r_cnt == c_cnt_last) begin
                        // Hold the counter on the last step so it never wraps.
                        r_diff       <= w_sd_next;
                        r_borrow_out <= w_bnext;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Scoreboard bench for serial_subtractor. A WIDTH=8 instance
//                runs directed vectors; a WIDTH=4 instance runs all operand
//                pairs. Expected results are queued at issue time and popped
//                by per-instance monitors on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    typedef struct packed {
        logic [7:0] diff;
        logic       bo;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bcnt8    = 0;
    int   bcnt4    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (bus8.busy) bcnt8++;
        if (bus8.done) begin
            check("done8_expected", 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) begin
                exp_t e;
                e = q8.pop_front();
                check("diff8", 32'(bus8.diff), 32'(e.diff));
                check("borrow8", 32'(bus8.borrow_out), 32'(e.bo));
                check("busy_cycles8", 32'(bcnt8), 32'd8);
            end
            bcnt8 = 0;
        end else if (!bus8.busy) begin
            bcnt8 = 0;
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        if (bus4.busy) bcnt4++;
        if (bus4.done) begin
            check("done4_expected", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) begin
                exp_t e;
                e = q4.pop_front();
                check("diff4", 32'(bus4.diff), 32'(e.diff));
                check("borrow4", 32'(bus4.borrow_out), 32'(e.bo));
                check("busy_cycles4", 32'(bcnt4), 32'd4);
            end
            bcnt4 = 0;
        end else if (!bus4.busy) begin
            bcnt4 = 0;
        end
    end

    // One operation on the 8-bit instance; operands are scrambled while busy.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb);
        bus8.a = a;
        bus8.b = b;
`ifdef SUB_BORROW_IN_EN
        bus8.borrow_in = bin;
`endif
        bus8.start = 1'b1;
        q8.push_back('{diff: ed, bo: eb});
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a = ~a;
        bus8.b = b ^ 8'h5A;
`ifdef SUB_BORROW_IN_EN
        bus8.borrow_in = ~bin;
`endif
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ed;
        ed = a - b;
        bus4.a = a;
        bus4.b = b;
        bus4.start = 1'b1;
        q4.push_back('{diff: {4'h0, ed}, bo: (a < b)});
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.a = ~a;
        bus4.b = ~b;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
`ifdef SUB_BORROW_IN_EN
        bus8.borrow_in = 1'b0;
        bus4.borrow_in = 1'b0;
`endif
        bus8.start = 1'b1;   // start during reset must be dropped
        repeat (2) @(posedge clk);
        #1;
        bus8.start = 1'b0;
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_diff", 32'(bus8.diff), 32'd0);
        check("rst_borrow", 32'(bus8.borrow_out), 32'd0);
        check("rst_busy4", 32'(bus4.busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(bus8.busy), 32'd0);

        run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        run8(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);
`ifdef SUB_BORROW_IN_EN
        run8(8'h05, 8'h03, 1'b1, 8'h01, 1'b0);
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        bus8.borrow_in = 1'b0;
`endif

        // start held high: one result every 10 cycles, operands perturbed mid-flight
        bus8.a = 8'h10;
        bus8.b = 8'h01;
        bus8.start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            q8.push_back('{diff: 8'h0F, bo: 1'b0});
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                if (k == 1) begin bus8.a = 8'h77; bus8.b = 8'hEE; end
                if (k == 8) begin bus8.a = 8'h10; bus8.b = 8'h01; end
            end
        end
        bus8.start = 1'b0;
        check("held_diff", 32'(bus8.diff), 32'h0F);

        // reset three cycles into an operation aborts it
        bus8.a = 8'h05;
        bus8.b = 8'h03;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus8.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus8.busy), 32'd0);
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_diff", 32'(bus8.diff), 32'd0);
        check("abort_borrow", 32'(bus8.borrow_out), 32'd0);
        repeat (12) @(posedge clk);
        #1;

        // exhaustive 4-bit sweep
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                run4(4'(ia), 4'(ib));

        repeat (3) @(posedge clk);
        #1;
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
